// File: rtl/booth_r4_seq.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, start/busy/done handshake.
// Optional data-dependent early finish when BOOTH_R4_SEQ_EARLY_EXIT_EN is defined.
module booth_r4_seq #(
    parameter int MBITS     = 12,
    parameter int NBITS     = 8,
    parameter int COUNTBITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [MBITS-1:0]       mpd,
    input  logic [NBITS-1:0]       mpr,
    output logic                   busy,
    output logic                   done,
    output logic [MBITS+NBITS-1:0] answer
);

    localparam int PW = MBITS + NBITS;
    localparam logic [COUNTBITS-1:0] LAST = COUNTBITS'(NBITS/2 - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [MBITS-1:0]     mpd_q;
    logic [NBITS-1:0]     mpr_q;
    logic [PW-1:0]        acc;
    logic [COUNTBITS-1:0] idx;

    logic                 accept;
    logic                 last;
    logic [NBITS:0]       mpr_ext;
    logic [2:0]           trip;
    logic [MBITS+1:0]     m_ext;
    logic [MBITS+1:0]     pp;
    logic [PW-1:0]        pp_shift;
    logic [PW-1:0]        sum;

    assign accept = start && (state_q == IDLE || state_q == DONE);

    // Recode the current digit and form the shifted partial product.
    always_comb begin
        mpr_ext  = {mpr_q, 1'b0};
        trip     = 3'(mpr_ext >> {idx, 1'b0});
        m_ext    = {{2{mpd_q[MBITS-1]}}, mpd_q};
        pp       = '0;
        case (trip)
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
        pp_shift = PW'($signed(pp)) << {idx, 1'b0};
        sum      = acc + pp_shift;
    end

`ifdef BOOTH_R4_SEQ_EARLY_EXIT_EN
    logic signed [NBITS-1:0] rem;

    // Arithmetic shift by 2i+1 leaves only sign copies iff mpr[NBITS-1:2i+1] are all equal.
    always_comb begin
        rem  = $signed(mpr_q) >>> {idx, 1'b1};
        last = (idx == LAST) || (rem == '0) || (rem == '1);
    end
`else
    always_comb begin
        last = (idx == LAST);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpd_q  <= '0;
            mpr_q  <= '0;
            acc    <= '0;
            idx    <= '0;
            answer <= '0;
        end else if (accept) begin
            mpd_q <= mpd;
            mpr_q <= mpr;
            acc   <= '0;
            idx   <= '0;
        end else if (state_q == RUN) begin
            acc <= sum;
            idx <= idx + 1'b1;
            if (last) begin
                answer <= sum;
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_seq.sv
// Directed bench for booth_r4_seq: latency, products, back-to-back starts and async reset.
// Expected latencies follow BOOTH_R4_SEQ_EARLY_EXIT_EN when defined.
module tb_booth_r4_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] mpd;
    logic [7:0]  mpr;
    logic        busy;
    logic        done;
    logic [19:0] answer;

    int total = 0;
    int bad   = 0;

`ifdef BOOTH_R4_SEQ_EARLY_EXIT_EN
    localparam int LAT_3_5  = 3;
    localparam int LAT_M1   = 2;
    localparam int LAT_2_3  = 3;
    localparam int LAT_A_1  = 2;
`else
    localparam int LAT_3_5  = 5;
    localparam int LAT_M1   = 5;
    localparam int LAT_2_3  = 5;
    localparam int LAT_A_1  = 5;
`endif

    booth_r4_seq #(
        .MBITS(12),
        .NBITS(8),
        .COUNTBITS(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .mpd(mpd),
        .mpr(mpr),
        .busy(busy),
        .done(done),
        .answer(answer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue one start, scramble operands afterwards, and time the done pulse.
    task automatic run_op(input string tag, input logic [11:0] m, input logic [7:0] r,
                          input logic [19:0] exp, input int lat);
        int n;
        int nb;
        @(negedge clk);
        start = 1'b1;
        mpd   = m;
        mpr   = r;
        @(negedge clk);
        start = 1'b0;
        mpd   = 12'($urandom);
        mpr   = 8'($urandom);
        n  = 1;
        nb = 0;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"},  32'(n), 32'(lat));
        chk({tag, "_busycnt"}, 32'(nb), 32'(lat - 1));
        chk({tag, "_ans"},  32'(answer), 32'(exp));
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"},  32'(answer), 32'(exp));
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        mpd   = '0;
        mpr   = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ans",  32'(answer), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        run_op("p3x5",   12'h003, 8'h05, 20'h0000F, LAT_3_5);
        run_op("m1xm1",  12'hFFF, 8'hFF, 20'h00001, LAT_M1);
        run_op("minmin", 12'h800, 8'h80, 20'h40000, 5);
        run_op("maxmax", 12'h7FF, 8'h7F, 20'h3F781, 5);

        // Start held high: RUN-time starts ignored, start in DONE chains the next op.
        @(negedge clk);
        start = 1'b1;
        mpd   = 12'h003;
        mpr   = 8'h05;
        @(negedge clk);
        mpd = 12'h7FF;
        mpr = 8'h7F;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b1_lat", 32'(n), 32'(LAT_3_5));
        chk("b2b1_ans", 32'(answer), 32'h0000F);
        @(negedge clk);
        chk("b2b2_busy", 32'(busy), 32'd1);
        mpd = 12'h001;
        mpr = 8'h01;
        n = 1;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b2_lat", 32'(n), 32'd5);
        chk("b2b2_ans", 32'(answer), 32'h3F781);
        @(negedge clk);
        chk("b2b2_pulse", 32'(done), 32'd0);
        chk("b2b2_idle",  32'(busy), 32'd0);

        // Abort in the second RUN cycle with an asynchronous reset.
        @(negedge clk);
        start = 1'b1;
        mpd   = 12'h7FF;
        mpr   = 8'h7F;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ans",  32'(answer), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        chk("abort_quiet", 32'(n), 32'd0);
        run_op("p2x3", 12'h002, 8'h03, 20'h00006, LAT_2_3);
        run_op("pAx1", 12'h00A, 8'h01, 20'h0000A, LAT_A_1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
